// File: rtl/multiport_register_file.sv
// rtl/multiport_register_file.sv - multi-port register file with busy scoreboard and optional write bypass
//
// Purpose:
//   NUM_READ combinational read ports and NUM_WRITE clocked write ports over
//   DEPTH registers of WIDTH bits. A per-register busy bit is set by a
//   reservation from decode and cleared by writeback. busy_count holds the
//   registered population count of the busy vector.
//
// Build option:
//   ZERO_REG_EN - when defined, register 0 reads as zero, ignores writes and
//                 can never be reserved.
//
// Ports:
//   clk         clock, all state changes on the rising edge
//   rst_n       asynchronous active-low reset, clears registers and busy bits
//   write_en    per write port enable
//   write_addr  packed write addresses, port i at [i*AW +: AW]
//   write_data  packed write data, port i at [i*WIDTH +: WIDTH]
//   read_addr   packed read addresses, port r at [r*AW +: AW]
//   read_data   packed combinational read data
//   read_busy   combinational busy flag of each addressed register
//   rsv_en      reserve request for rsv_addr
//   rsv_addr    register being reserved
//   busy_count  registered number of busy registers
module multiport_register_file #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int NUM_READ  = 2,
  parameter int NUM_WRITE = 2,
  parameter int BYPASS    = 1,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_WRITE-1:0]       write_en,
  input  logic [NUM_WRITE*AW-1:0]    write_addr,
  input  logic [NUM_WRITE*WIDTH-1:0] write_data,
  input  logic [NUM_READ*AW-1:0]     read_addr,
  output logic [NUM_READ*WIDTH-1:0]  read_data,
  output logic [NUM_READ-1:0]        read_busy,
  input  logic                       rsv_en,
  input  logic [AW-1:0]              rsv_addr,
  output logic [CW-1:0]              busy_count
);

`ifdef ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic [WIDTH-1:0] regs     [DEPTH];
  logic [WIDTH-1:0] regs_nxt [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic [CW-1:0]    count_nxt;
  logic [AW-1:0]    wa;

  logic [AW-1:0]    ra;
  logic [WIDTH-1:0] rdat;
  logic             rbusy;

  // Next state. Ports are applied in ascending order so the highest enabled
  // port targeting an address is the one that lands. The reservation is
  // applied last so a same-cycle set beats the writeback clear.
  always_comb begin
    regs_nxt  = regs;
    busy_nxt  = busy;
    wa        = '0;
    count_nxt = '0;
    for (int w = 0; w < NUM_WRITE; w++) begin
      wa = write_addr[w*AW +: AW];
      if (write_en[w] && !(ZERO_REG && wa == '0)) begin
        regs_nxt[wa] = write_data[w*WIDTH +: WIDTH];
        busy_nxt[wa] = 1'b0;
      end
    end
    if (rsv_en && !(ZERO_REG && rsv_addr == '0)) begin
      busy_nxt[rsv_addr] = 1'b1;
    end
    // Count the post-edge busy vector so busy_count tracks busy exactly.
    for (int i = 0; i < DEPTH; i++) begin
      count_nxt = count_nxt + CW'(busy_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      busy       <= '0;
      busy_count <= '0;
    end else begin
      regs       <= regs_nxt;
      busy       <= busy_nxt;
      busy_count <= count_nxt;
    end
  end

  // Read ports. With bypass, a same-cycle write to the addressed register
  // forwards its data and reports not busy, since that value is the result
  // the reader was waiting on. Reservations only act through the busy flops,
  // so they show up one cycle later.
  always_comb begin
    read_data = '0;
    read_busy = '0;
    ra        = '0;
    rdat      = '0;
    rbusy     = 1'b0;
    for (int r = 0; r < NUM_READ; r++) begin
      ra    = read_addr[r*AW +: AW];
      rdat  = regs[ra];
      rbusy = busy[ra];
      if (BYPASS != 0) begin
        for (int w = 0; w < NUM_WRITE; w++) begin
          if (write_en[w] && write_addr[w*AW +: AW] == ra && !(ZERO_REG && ra == '0)) begin
            rdat  = write_data[w*WIDTH +: WIDTH];
            rbusy = 1'b0;
          end
        end
      end
      read_data[r*WIDTH +: WIDTH] = rdat;
      read_busy[r]                = rbusy;
    end
  end

endmodule

// File: doc/multiport_register_file.md
Name: multiport_register_file

Overview:
Parametrised successor to the team's 2-read/1-write register file. It provides NUM_READ asynchronous read ports and NUM_WRITE synchronous write ports, with an asynchronous reset that clears all registers. A per-register busy scoreboard lets the datapath stall on pending writebacks. A build-time write-to-read bypass is also available. It sits between decode (read and reserve) and writeback (write) in the CPU datapath.

Parameters:
WIDTH, 8, width of each register in bits
DEPTH, 8, number of registers; power of two, >= 2
NUM_READ, 2, number of read ports, >= 1
NUM_WRITE, 2, number of write ports, >= 1
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = reads return stored value only
AW (localparam), $clog2(DEPTH), address width
CW (localparam), $clog2(DEPTH+1), busy counter width

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
write_en  in  NUM_WRITE  per-port write enable
write_addr  in  NUM_WRITE*AW  packed write addresses; port i = bits [i*AW +: AW]
write_data  in  NUM_WRITE*WIDTH  packed write data; port i = bits [i*WIDTH +: WIDTH]
read_addr  in  NUM_READ*AW  packed read addresses
read_data  out  NUM_READ*WIDTH  packed read data, combinational
read_busy  out  NUM_READ  busy flag of each addressed register, combinational
rsv_en  in  1  reserve request: marks rsv_addr busy
rsv_addr  in  AW  register being reserved
busy_count  out  CW  number of registers currently busy, registered

Behaviour:
- Reset: one clock (clk) and one reset (rst_n). rst_n low asynchronously clears every register to 0, every busy bit to 0, and busy_count to 0. After release, first update is on the next rising clk edge.
- Reads: purely combinational, zero latency.
  - read_data port r = regs[read_addr r].
  - read_busy port r = busy[read_addr r].
- Writes: on rising clk, regs[write_addr i] <= write_data i for each i with write_en[i]=1.
- Write conflict: several enabled ports with the same address -> the highest port index wins. This applies to both storage and bypass.
- Bypass (BYPASS=1): if any enabled write port matches read_addr r in the current cycle, read_data r = that port's write_data (highest index wins). read_busy r = 0 for that port.
- Bypass (BYPASS=0): reads show the pre-edge stored value and the registered busy bit.
- Scoreboard, on rising clk:
  - Every enabled write port clears busy[write_addr i].
  - rsv_en=1 sets busy[rsv_addr].
  - Set and clear on the same address in the same cycle -> set wins (new producer issued). The write data is still stored.
  - A reservation never affects read_busy in the same cycle; it is visible from the next cycle.
- Reserve of an already-busy register: stays busy, count unchanged.
- Write to a non-busy register: data stored, busy stays 0, count unchanged.
- busy_count: registered population count of the busy vector, updated each edge to the count of the next-state busy vector. Never exceeds DEPTH and never wraps.
- No X propagation: out-of-range addresses cannot occur because DEPTH is a power of two.

Optional Feature:
ZERO_REG_EN
- Defined:
  - Register 0 is hardwired to zero; writes to address 0 are discarded.
  - read_data for address 0 is always 0, including under bypass.
  - rsv_en with rsv_addr=0 is ignored, so busy[0] is always 0 and address 0 never counts toward busy_count.
- Undefined: register 0 is an ordinary register.

Test Plan:
1. Reset mid-operation: write 0xA5 to reg 3, reserve reg 5, then pulse rst_n low between edges -> immediately read_data(3)=0x00, read_busy(5)=0, busy_count=0.
2. Dual-write conflict: write_en=2'b11, both ports addr 4, data 0x11 (port 0) / 0x22 (port 1) -> with BYPASS=1, read of addr 4 shows 0x22 in the same cycle; after the edge, stored value = 0x22.
3. Bypass vs none: stored reg 2 = 0x10, write 0x7F to reg 2 -> BYPASS=1 read returns 0x7F combinationally; BYPASS=0 returns 0x10 until after the edge, then 0x7F.
4. Scoreboard: reserve regs 1, 2, 3 on three consecutive cycles -> busy_count 1, 2, 3. Then write reg 2 -> busy_count=2, read_busy(2)=0.
5. Set wins: reg 6 busy, same cycle write reg 6 with 0x3C and rsv_en on reg 6 -> after the edge, busy[6]=1, busy_count unchanged, stored value 0x3C.
6. ZERO_REG_EN defined: write 0xFF to reg 0 and rsv_en on reg 0 -> read_data(0)=0x00 (also during bypass), read_busy(0)=0, busy_count=0.
